// File: rtl/dmem_pkg.sv
// Shared state type and default geometry for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 64;
  localparam int DMEM_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from rr_ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] sel;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    pos       = 0;
    sel       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_CORES) pos = pos - NUM_CORES;
      sel = IDX_W'(pos);
      if (!gnt_valid && req[sel]) begin
        gnt_valid = 1'b1;
        gnt[sel]  = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of the shared data RAM; one access in flight, out-of-range flagged.
// Optional grant/conflict counters are built when DMEM_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request; winner's addr/data/we latched on the leaving edge
// ACCESS | RAM strobe (mem_rd or mem_wr) high for this single cycle
// DONE   | core_ack/core_err pulse to the winner; rr_ptr moves past it
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MEM_DEPTH = DMEM_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic                        core_err,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wr,
  output logic                        mem_rd,
  input  logic [DATA_W-1:0]           mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [NUM_CORES*16-1:0]     stat_grants,
  output logic [15:0]                 stat_conflicts
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  dmem_state_t          state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     cur;
  logic [NUM_CORES-1:0] cur_onehot;
  logic                 cur_err;
  logic                 mem_wr_q;

  logic [NUM_CORES-1:0] gnt_onehot;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 req_any;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_we;
  logic                 sel_err;
  logic [IDX_W-1:0]     ptr_next;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES),
    .IDX_W    (IDX_W)
  ) u_rr (
    .req      (core_req),
    .rr_ptr   (rr_ptr),
    .gnt      (gnt_onehot),
    .gnt_idx  (gnt_idx),
    .gnt_valid(req_any)
  );

  assign sel_addr  = core_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = core_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_we    = core_we[gnt_idx];
  assign sel_err   = {1'b0, sel_addr} >= DEPTH_LIM;
  assign ptr_next  = (cur == IDX_W'(NUM_CORES-1)) ? '0 : cur + 1'b1;

  // A store caught in ACCESS by reset must not reach the RAM on that edge.
  assign mem_wr = mem_wr_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur        <= '0;
      cur_onehot <= '0;
      cur_err    <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= '0;
      core_err   <= 1'b0;
      core_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_any) begin
            cur        <= gnt_idx;
            cur_onehot <= gnt_onehot;
            cur_err    <= sel_err;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_wr_q   <= !sel_err && sel_we;
            mem_rd     <= !sel_err && !sel_we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wr_q <= 1'b0;
          mem_rd   <= 1'b0;
          if (cur_err)     core_rdata <= '0;
          else if (mem_rd) core_rdata <= mem_rdata;
          core_ack <= cur_onehot;
          core_err <= cur_err;
          state    <= DONE;
        end
        DONE: begin
          core_ack <= '0;
          core_err <= 1'b0;
          rr_ptr   <= ptr_next;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic conflict;
  assign conflict = (core_req & (core_req - NUM_CORES'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      if (state == IDLE && conflict && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (state == DONE && stat_grants[int'(cur)*16 +: 16] != 16'hFFFF)
        stat_grants[int'(cur)*16 +: 16] <= stat_grants[int'(cur)*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule
